// File: rtl/clk_div_ctrl_if.sv
// Configuration request channel of the clock divider controller:
// factor request with valid/ready handshake and an error pulse back.
interface clk_div_ctrl_if #(
   parameter int CNT_W = 9
);
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_factor;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_factor,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_factor,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the odd/even clock divider: counter, 50%-duty output,
// glitch-free enable/disable and factor-change sequencing.
module clk_div_ctrl #(
   parameter int MAX_FACTOR     = 256,
   parameter int DEFAULT_FACTOR = 4,
   parameter int CNT_W          = $clog2(MAX_FACTOR + 1)
) (
   input  logic             clk_in,
   input  logic             rstn,
   input  logic             i_enable,
   clk_div_ctrl_if.slave    cfg_if,
   output logic [CNT_W-1:0] o_cur_factor,
   output logic             o_div_out,
   output logic             o_div_active,
   output logic             o_period_tick
);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_F   = CNT_W'(2);
   localparam logic [CNT_W-1:0] MAX_F   = CNT_W'(MAX_FACTOR);
   localparam logic [CNT_W-1:0] DEF_F   = CNT_W'(DEFAULT_FACTOR);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_PEND, S_DRAIN} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_cur_factor;
   logic [CNT_W-1:0] r_pend_factor;
   logic             r_cfg_err;
   logic             r_hi;
   logic             r_mid;
   logic             r_neg;

   logic             w_cfg_ready;
   logic             w_active;
   logic             w_end;
   logic             w_xfer;
   logic             w_legal;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_factor_next;
   logic [CNT_W-1:0] w_half;
   logic [CNT_W-1:0] w_half_ceil;
   logic             w_active_next;

   assign w_xfer  = cfg_if.cfg_valid && w_cfg_ready;
   assign w_legal = (cfg_if.cfg_factor >= MIN_F) && (cfg_if.cfg_factor <= MAX_F);

   // State register
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) r_state <= S_OFF;
      else       r_state <= w_state_next;
   end

   // Next-state logic; OFF ignores enable in any cycle that carries a transfer
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_OFF:   if (!w_xfer && i_enable) w_state_next = S_RUN;
         S_RUN: begin
            if (w_end)                   w_state_next = i_enable ? S_RUN : S_OFF;
            else if (w_xfer && w_legal)  w_state_next = S_PEND;
            else if (!i_enable)          w_state_next = S_DRAIN;
         end
         S_PEND:  if (w_end) w_state_next = i_enable ? S_RUN : S_DRAIN;
         S_DRAIN: if (w_end) w_state_next = i_enable ? S_RUN : S_OFF;
         default: w_state_next = S_OFF;
      endcase
   end

   // Moore outputs
   always_comb begin
      w_cfg_ready = (r_state == S_OFF) || (r_state == S_RUN);
      w_active    = (r_state != S_OFF);
      w_end       = w_active && (r_cnt == r_cur_factor - ONE);
   end

   // Factor only changes at a period boundary (or while idle)
   always_comb begin
      w_factor_next = r_cur_factor;
      if (w_xfer && w_legal && ((r_state == S_OFF) || (r_state == S_RUN && w_end)))
         w_factor_next = cfg_if.cfg_factor;
      else if (r_state == S_PEND && w_end)
         w_factor_next = r_pend_factor;
      w_active_next = (w_state_next != S_OFF);
      if (!w_active_next || !w_active || w_end) w_cnt_next = '0;
      else                                      w_cnt_next = r_cnt + ONE;
      w_half      = w_factor_next >> 1;
      w_half_ceil = w_half + {{(CNT_W-1){1'b0}}, w_factor_next[0]};
   end

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         r_cnt         <= '0;
         r_cur_factor  <= DEF_F;
         r_pend_factor <= DEF_F;
         r_cfg_err     <= 1'b0;
         r_hi          <= 1'b0;
         r_mid         <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_next;
         r_cur_factor <= w_factor_next;
         r_cfg_err    <= w_xfer && !w_legal;
         if (r_state == S_RUN && !w_end && w_xfer && w_legal)
            r_pend_factor <= cfg_if.cfg_factor;
         r_hi  <= w_active_next && (w_cnt_next < w_half_ceil);
         r_mid <= w_active_next && w_factor_next[0] && (w_cnt_next == w_half);
      end
   end

   // Odd factors lose the second half of the middle cycle via this negedge flop
   always_ff @(negedge clk_in or negedge rstn) begin
      if (!rstn) r_neg <= 1'b0;
      else       r_neg <= r_mid;
   end

   assign o_div_out        = r_hi & ~r_neg;
   assign o_div_active     = w_active;
   assign o_period_tick    = w_end;
   assign o_cur_factor     = r_cur_factor;
   assign cfg_if.cfg_ready = w_cfg_ready;
   assign cfg_if.cfg_err   = r_cfg_err;
endmodule
